// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler beside EX: sequences MULT/MULTU/DIV/DIVU,
// stalls the front of the pipe while busy and emits one HI/LO write per op.
module muldiv_sched #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        rhl_wr,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    logic        sgn_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        dz;

    logic        capture;
    logic        sgn_in;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        neg_q;
    logic        neg_r;

    assign capture = (state == IDLE) && start && !flush;
    assign sgn_in  = !op[0];
    assign abs_a   = (sgn_in && src_a[31]) ? -src_a : src_a;
    assign abs_b   = (sgn_in && src_b[31]) ? -src_b : src_b;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod = sgn_q
        ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q}
        : {32'b0, a_q} * {32'b0, b_q};

    assign shifted = {rem, quo[31]};
    assign diff    = {1'b0, shifted} - {2'b0, dvs};
    assign neg_q   = sgn_q && (a_q[31] ^ b_q[31]);
    assign neg_r   = sgn_q && a_q[31];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nx = op[1] ? DIV : MUL;
                MUL:  if (cnt == 6'd0) state_nx = DONE;
                DIV:  if (cnt == 6'd0) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            sgn_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz     <= 1'b0;
        end else if (capture) begin
            sgn_q <= sgn_in;
            a_q   <= src_a;
            b_q   <= src_b;
            dz    <= 1'b0;
            rem   <= '0;
            quo   <= abs_a;
            dvs   <= abs_b;
            cnt   <= op[1] ? 6'(DIV_ITER - 1) : 6'(MUL_LAT - 1);
        end else begin
            case (state)
                MUL: begin
                    res_hi <= prod[63:32];
                    res_lo <= prod[31:0];
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                DIV: begin
                    rem <= diff[33] ? shifted[31:0] : diff[31:0];
                    quo <= {quo[30:0], ~diff[33]};
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                FIX: begin
                    if (!flush) begin
                        if (b_q == 32'd0) begin
                            res_lo <= 32'hFFFF_FFFF;
                            res_hi <= a_q;
                            dz     <= 1'b1;
                        end else begin
                            res_lo <= neg_q ? -quo : quo;
                            res_hi <= neg_r ? -rem : rem;
                        end
                    end
                end
                DONE: begin
                    if (!flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs track the committed HI/LO, except during the DONE write.
    assign busy      = (state != IDLE);
    assign stall_req = resetn && (capture || state inside {MUL, DIV, FIX});
    assign rhl_wr    = resetn && (state == DONE) && !flush;
    assign hi_out    = (state == DONE) ? res_hi : hi_q;
    assign lo_out    = (state == DONE) ? res_lo : lo_q;
    assign div_zero  = dz;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed and random ops against an arithmetic
// reference model, plus flush, async reset and back-to-back scenarios.
module tb_muldiv_sched;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        rhl_wr;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_sched dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .rhl_wr    (rhl_wr),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ref_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] h,
                          output logic [31:0] l, output logic z,
                          output int lat);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        z  = 1'b0;
        h  = '0;
        l  = '0;
        lat = o[1] ? 34 : 5;
        case (o)
            2'b00: begin
                sp = sa * sb;
                h = sp[63:32];
                l = sp[31:0];
            end
            2'b01: begin
                up = ua * ub;
                h = up[63:32];
                l = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                    z = 1'b1;
                end else if (o == 2'b10) begin
                    sp = sa / sb;
                    l = sp[31:0];
                    sp = sa % sb;
                    h = sp[31:0];
                end else begin
                    up = ua / ub;
                    l = up[31:0];
                    up = ua % ub;
                    h = up[31:0];
                end
            end
        endcase
    endtask

    // Drives one op with start held through the stall; returns what was seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit drop,
                          output int lat, output int stalls,
                          output bit done_stall, output logic [31:0] h,
                          output logic [31:0] l, output logic z);
        lat = 0;
        stalls = 0;
        done_stall = 1'b1;
        h = 'x;
        l = 'x;
        z = 1'bx;
        @(negedge clk);
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        while (lat < 100) begin
            if (rhl_wr === 1'b1) begin
                h = hi_out;
                l = lo_out;
                z = div_zero;
                done_stall = stall_req;
                break;
            end
            if (stall_req === 1'b1) stalls++;
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        if (drop || lat >= 100) start = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (rhl_wr === 1'b1) c++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, stall_req, rhl_wr, div_zero, hi_out, lo_out} !== '0)
            $display("FAIL reset_outputs got %b%b%b%b %h %h exp all 0",
                     busy, stall_req, rhl_wr, div_zero, hi_out, lo_out);
        else pass_cnt++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, st, pul;
        bit ds;
        logic [31:0] h, l;
        logic z;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if (lat != 5) $display("FAIL multu_latency got %0d exp 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (st != 5 || ds !== 1'b0)
            $display("FAIL multu_stall got %0d/%b exp 5/0", st, ds);
        else pass_cnt++;
        total_cnt++;
        if ({h, l} !== {32'd1, 32'hFFFF_FFFE})
            $display("FAIL multu_result got %h_%h exp 1_fffffffe", h, l);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL done_start_ignored got busy=%b exp 0", busy);
        else pass_cnt++;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, lat, st, ds, h, l, z);
        count_pulses(6, pul);
        total_cnt++;
        if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB})
            $display("FAIL mult_result got %h_%h exp ffffffff_ffffffeb", h, l);
        else pass_cnt++;
        total_cnt++;
        if (lat != 5 || pul != 0)
            $display("FAIL mult_pulse got lat=%0d extra=%0d exp 5/0", lat, pul);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int lat, st;
        bit ds;
        logic [31:0] h, l;
        logic z;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if (lat != 34 || st != 34 || ds !== 1'b0)
            $display("FAIL div_timing got lat=%0d st=%0d ds=%b exp 34/34/0",
                     lat, st, ds);
        else pass_cnt++;
        total_cnt++;
        if ({h, l, z} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0})
            $display("FAIL div_neg got %h_%h z=%b exp ffffffff_fffffffd z=0",
                     h, l, z);
        else pass_cnt++;
        run_op(2'b11, 32'd100, 32'd7, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if ({h, l} !== {32'd2, 32'd14})
            $display("FAIL divu_result got %h_%h exp 2_e", h, l);
        else pass_cnt++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if ({h, l, z} !== {32'd0, 32'h8000_0000, 1'b0})
            $display("FAIL div_overflow got %h_%h z=%b exp 0_80000000 z=0",
                     h, l, z);
        else pass_cnt++;
        run_op(2'b11, 32'd5, 32'd0, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if ({h, l, z} !== {32'd5, 32'hFFFF_FFFF, 1'b1} || lat != 34)
            $display("FAIL divu_zero got %h_%h z=%b lat=%0d exp 5_ffffffff 1 34",
                     h, l, z, lat);
        else pass_cnt++;
        run_op(2'b11, 32'd9, 32'd3, 1'b1, lat, st, ds, h, l, z);
        total_cnt++;
        if ({h, l, z} !== {32'd0, 32'd3, 1'b0})
            $display("FAIL dz_clear got %h_%h z=%b exp 0_3 z=0", h, l, z);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int lat, st, pul;
        bit ds;
        logic [31:0] h, l;
        logic z;
        run_op(2'b11, 32'd50, 32'd5, 1'b1, lat, st, ds, h, l, z);
        @(negedge clk);
        op = 2'b10;
        src_a = 32'd1000;
        src_b = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || stall_req !== 1'b0)
            $display("FAIL flush_div got busy=%b stall=%b exp 0/0",
                     busy, stall_req);
        else pass_cnt++;
        count_pulses(40, pul);
        total_cnt++;
        if (pul != 0) $display("FAIL flush_no_wr got %0d exp 0", pul);
        else pass_cnt++;
        total_cnt++;
        if ({hi_out, lo_out} !== {32'd0, 32'd10})
            $display("FAIL flush_hilo got %h_%h exp 0_a", hi_out, lo_out);
        else pass_cnt++;
        start = 1'b1;
        flush = 1'b1;
        #1;
        total_cnt++;
        if (stall_req !== 1'b0)
            $display("FAIL flush_idle_stall got %b exp 0", stall_req);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL flush_idle_capture got busy=%b exp 0", busy);
        else pass_cnt++;
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, st, pul;
        bit ds;
        logic [31:0] h, l, eh, el;
        logic z, ez;
        int elat;
        @(negedge clk);
        op = 2'b00;
        src_a = 32'd123;
        src_b = 32'd456;
        start = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({busy, stall_req, rhl_wr, div_zero, hi_out, lo_out} !== '0)
            $display("FAIL reset_mid got %b%b%b%b %h %h exp all 0",
                     busy, stall_req, rhl_wr, div_zero, hi_out, lo_out);
        else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        count_pulses(4, pul);
        total_cnt++;
        if (pul != 0) $display("FAIL reset_spurious got %0d exp 0", pul);
        else pass_cnt++;
        ref_op(2'b00, 32'd12345, 32'hFFFF_FFFA, eh, el, ez, elat);
        run_op(2'b00, 32'd12345, 32'hFFFF_FFFA, 1'b1, lat, st, ds, h, l, z);
        count_pulses(5, pul);
        total_cnt++;
        if ({h, l} !== {eh, el} || lat != elat || pul != 0)
            $display("FAIL reset_recover got %h_%h lat=%0d x=%0d exp %h_%h %0d 0",
                     h, l, lat, pul, eh, el, elat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, st;
        bit ds;
        logic [31:0] h, l, eh, el;
        logic z, ez;
        int elat;
        run_op(2'b01, 32'd70000, 32'd70000, 1'b0, lat, st, ds, h, l, z);
        ref_op(2'b01, 32'd70000, 32'd70000, eh, el, ez, elat);
        total_cnt++;
        if ({h, l} !== {eh, el})
            $display("FAIL b2b_first got %h_%h exp %h_%h", h, l, eh, el);
        else pass_cnt++;
        run_op(2'b10, 32'hFFFF_FC18, 32'd7, 1'b1, lat, st, ds, h, l, z);
        ref_op(2'b10, 32'hFFFF_FC18, 32'd7, eh, el, ez, elat);
        total_cnt++;
        if ({h, l} !== {eh, el} || lat != elat)
            $display("FAIL b2b_second got %h_%h lat=%0d exp %h_%h %0d",
                     h, l, lat, eh, el, elat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, st, elat;
        bit ds;
        logic [31:0] h, l, eh, el, a, b;
        logic z, ez;
        logic [1:0] o;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1, 2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            ref_op(o, a, b, eh, el, ez, elat);
            run_op(o, a, b, 1'b1, lat, st, ds, h, l, z);
            total_cnt++;
            if ({h, l, z} !== {eh, el, ez} || lat != elat || st != elat)
                $display("FAIL rand_%0d op=%0d a=%h b=%h got %h_%h z=%b lat=%0d st=%0d exp %h_%h z=%b lat=%0d",
                         i, o, a, b, h, l, z, lat, st, eh, el, ez, elat);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
